// File: rtl/fifo_pkg.sv
// Shared defaults for the single-clock FIFO and its pointer counters.
package fifo_pkg;

    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_DEPTH  = 8;
    localparam int FIFO_ADDR_W = $clog2(FIFO_DEPTH);

endpackage : fifo_pkg

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer counter: ADDR_W address bits plus one MSB that toggles on each wrap.
import fifo_pkg::*;

module fifo_ptr #(
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    output logic [ADDR_W:0]   ptr_o,
    output logic [ADDR_W-1:0] addr_o
);

    localparam int PTR_W = ADDR_W + 1;

    logic [ADDR_W:0] ptr_q, ptr_d;

    // Natural overflow of the full-width counter gives the mod 2*DEPTH wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o  = ptr_q;
    assign addr_o = ptr_q[ADDR_W-1:0];

endmodule : fifo_ptr

// File: rtl/fifo_buffer.sv
// Single-clock FIFO with registered read data, wrap-bit full/empty detection
// and exported pointers for debug.
import fifo_pkg::*;

module fifo_buffer #(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_e,
    input  logic              read_e,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] write_ptr,
    output logic [ADDR_W-1:0] read_ptr
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [ADDR_W:0]   wptr, rptr;
    logic              wr_acc, rd_acc;

    // Accept decisions use the flags as they stand before the edge, so a full
    // FIFO drops a simultaneous write and an empty one ignores a simultaneous read.
    assign wr_acc = write_e && !full;
    assign rd_acc = read_e && !empty;

    fifo_ptr #(.ADDR_W(ADDR_W)) u_wptr (
        .clk    (clk),
        .reset  (reset),
        .en_i   (wr_acc),
        .ptr_o  (wptr),
        .addr_o (write_ptr)
    );

    fifo_ptr #(.ADDR_W(ADDR_W)) u_rptr (
        .clk    (clk),
        .reset  (reset),
        .en_i   (rd_acc),
        .ptr_o  (rptr),
        .addr_o (read_ptr)
    );

    assign empty = (wptr == rptr);
    assign full  = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) && (wptr[ADDR_W] != rptr[ADDR_W]);

    // Storage is deliberately left unreset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[write_ptr] <= data_in;
        end
    end

    always_comb begin
        data_out_d = data_out_q;
        if (rd_acc) begin
            data_out_d = mem_q[read_ptr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule : fifo_buffer

// File: tb/tb_fifo_buffer.sv
// Directed self-checking bench for fifo_buffer with hand-computed expectations.
module tb_fifo_buffer;

    logic       clk;
    logic       reset;
    logic       write_e;
    logic       read_e;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic [2:0] write_ptr;
    logic [2:0] read_ptr;

    int n_chk  = 0;
    int n_pass = 0;

    fifo_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .write_e   (write_e),
        .read_e    (read_e),
        .data_in   (data_in),
        .data_out  (data_out),
        .full      (full),
        .empty     (empty),
        .write_ptr (write_ptr),
        .read_ptr  (read_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int fill_v [8] = '{1, 9, 7, 3, 4, 6, 8, 10};

    initial begin
        reset   = 1'b1;
        write_e = 1'b1;
        read_e  = 1'b0;
        data_in = 8'hFF;

        // Reset held across edges with a pending write
        step();
        step();
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_wptr", 32'(write_ptr), 0);
        chk("rst_rptr", 32'(read_ptr), 0);
        chk("rst_dout", 32'(data_out), 0);
        step();
        chk("rst_hold_empty", 32'(empty), 1);
        chk("rst_hold_wptr", 32'(write_ptr), 0);
        write_e = 1'b0;
        reset   = 1'b0;
        step();
        chk("post_rst_empty", 32'(empty), 1);

        // Fill
        write_e = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = 8'(fill_v[i]);
            step();
            chk("fill_empty", 32'(empty), 0);
            chk("fill_full", 32'(full), (i == 7) ? 1 : 0);
            chk("fill_wptr", 32'(write_ptr), (i + 1) % 8);
        end

        // Write while full is dropped
        data_in = 8'd99;
        step();
        chk("ovf_wptr", 32'(write_ptr), 0);
        chk("ovf_full", 32'(full), 1);
        write_e = 1'b0;

        // Drain, including two reads past empty
        read_e = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("drain_dout", 32'(data_out), (i < 8) ? fill_v[i] : 10);
            chk("drain_full", 32'(full), 0);
            chk("drain_empty", 32'(empty), (i >= 7) ? 1 : 0);
            chk("drain_rptr", 32'(read_ptr), (i < 8) ? (i + 1) % 8 : 0);
        end
        read_e = 1'b0;

        // Occupancy 3, then simultaneous read/write
        write_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = 8'(5 + i);
            step();
        end
        read_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = 8'(20 + i);
            step();
            chk("rw_dout", 32'(data_out), 5 + i);
            chk("rw_empty", 32'(empty), 0);
            chk("rw_full", 32'(full), 0);
        end
        chk("rw_wptr", 32'(write_ptr), 6);
        chk("rw_rptr", 32'(read_ptr), 3);
        write_e = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rw_tail_dout", 32'(data_out), 20 + i);
        end
        chk("rw_tail_empty", 32'(empty), 1);
        read_e = 1'b0;

        // Simultaneous read/write when full
        write_e = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = 8'(30 + i);
            step();
        end
        chk("f_full", 32'(full), 1);
        read_e  = 1'b1;
        data_in = 8'd77;
        step();
        chk("frw_dout", 32'(data_out), 30);
        chk("frw_full", 32'(full), 0);
        chk("frw_wptr", 32'(write_ptr), 6);
        chk("frw_rptr", 32'(read_ptr), 7);
        write_e = 1'b0;
        for (int i = 1; i < 8; i++) begin
            step();
            chk("frw_drain", 32'(data_out), 30 + i);
        end
        chk("frw_empty", 32'(empty), 1);
        chk("frw_rptr2", 32'(read_ptr), 6);

        // Simultaneous read/write when empty
        write_e = 1'b1;
        data_in = 8'd42;
        step();
        chk("erw_dout", 32'(data_out), 37);
        chk("erw_empty", 32'(empty), 0);
        chk("erw_wptr", 32'(write_ptr), 7);
        chk("erw_rptr", 32'(read_ptr), 6);
        write_e = 1'b0;
        step();
        chk("erw_read", 32'(data_out), 42);
        chk("erw_empty2", 32'(empty), 1);
        read_e = 1'b0;

        // Async reset between edges with 4 entries queued
        write_e = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in = 8'(50 + i);
            step();
        end
        write_e = 1'b0;
        chk("ar_pre_wptr", 32'(write_ptr), 3);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_empty", 32'(empty), 1);
        chk("ar_full", 32'(full), 0);
        chk("ar_wptr", 32'(write_ptr), 0);
        chk("ar_rptr", 32'(read_ptr), 0);
        chk("ar_dout", 32'(data_out), 0);
        #1;
        reset = 1'b0;

        // Normal operation after reset release
        write_e = 1'b1;
        data_in = 8'd55;
        step();
        write_e = 1'b0;
        read_e  = 1'b1;
        step();
        chk("ar_after_dout", 32'(data_out), 55);
        chk("ar_after_empty", 32'(empty), 1);
        read_e = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_fifo_buffer
